// File: rtl/memory_access.sv
// Memory-access pipeline stage: takes the execute stage's registered
// outputs, runs loads/stores on a ready/valid data bus, flags misaligned
// accesses and formats load data before handing results to writeback.
//
// Bus handshake: mem_req rises on the clock edge after a memory operation
// is accepted. mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb then stay
// unchanged until a cycle in which mem_ready is high. That cycle completes
// the transfer, and mem_rdata is sampled in the same cycle. The bus may
// assert mem_ready in the first cycle mem_req is high. mem_ready is ignored
// while no request is outstanding.
module memory_access (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out,
    input  logic [31:0] next_pc_in,
    output logic [31:0] next_pc_out,
    input  logic [31:0] alu_data_in,
    output logic [31:0] alu_data_out,
    input  logic [31:0] csr_data_in,
    output logic [31:0] csr_data_out,
    input  logic [31:0] rs2_data_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [1:0]  load_store_size_in,
    input  logic        load_signed_in,
    input  logic        bypass_memory_in,
    input  logic [1:0]  write_select_in,
    output logic [1:0]  write_select_out,
    input  logic [4:0]  rd_address_in,
    output logic [4:0]  rd_address_out,
    input  logic [11:0] csr_address_in,
    output logic [11:0] csr_address_out,
    input  logic        csr_write_in,
    output logic        csr_write_out,
    input  logic        mret_in,
    output logic        mret_out,
    input  logic        wfi_in,
    output logic        wfi_out,
    input  logic        valid_in,
    output logic        valid_out,
    input  logic [3:0]  ecause_in,
    output logic [3:0]  ecause_out,
    input  logic        exception_in,
    output logic        exception_out,
    input  logic        stall,
    input  logic        invalidate,
    output logic        mem_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data_out,
    output logic        debug_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t      state;
    logic        killed;

    logic        mem_op;
    logic        misaligned;
    logic        start;
    logic        capture;
    logic [31:0] shifted;
    logic [31:0] load_fmt;
    logic [3:0]  strobe;
    logic [31:0] wdata_rep;

    assign debug_state = state;

    // Decode the request, the handshake stall and the pass-through capture
    // enable.
    always_comb begin
        mem_op     = valid_in & ~exception_in & ~bypass_memory_in & (load_in | store_in);
        misaligned = ((load_store_size_in == 2'b01) & alu_data_in[0]) |
                     ((load_store_size_in == 2'b10) & (alu_data_in[1:0] != 2'b00));
        start      = (state == IDLE) & mem_op & ~misaligned & ~stall & ~invalidate;
        mem_busy   = start | ((state == ACCESS) & ~mem_ready);
        capture    = ((state == IDLE) & ~start & ~stall) | ((state == ACCESS) & mem_ready);
    end

    // Byte strobes and store data replicated across all lanes.
    always_comb begin
        strobe    = 4'b1111;
        wdata_rep = rs2_data_in;
        case (load_store_size_in)
            2'b00: begin
                strobe    = 4'b0001 << alu_data_in[1:0];
                wdata_rep = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
                strobe    = 4'b0011 << alu_data_in[1:0];
                wdata_rep = {2{rs2_data_in[15:0]}};
            end
            default: begin
                strobe    = 4'b1111;
                wdata_rep = rs2_data_in;
            end
        endcase
    end

    // Load formatting: select the addressed lane, then sign- or zero-extend.
    always_comb begin
        shifted  = mem_rdata >> {alu_data_in[1:0], 3'b000};
        load_fmt = shifted;
        case (load_store_size_in)
            2'b00:   load_fmt = load_signed_in ? {{24{shifted[7]}}, shifted[7:0]}
                                               : {24'b0, shifted[7:0]};
            2'b01:   load_fmt = load_signed_in ? {{16{shifted[15]}}, shifted[15:0]}
                                               : {16'b0, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    // Pass-through pipeline registers. They are captured when the stage
    // retires an instruction, and otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out           <= 32'b0;
            next_pc_out      <= 32'b0;
            alu_data_out     <= 32'b0;
            csr_data_out     <= 32'b0;
            write_select_out <= 2'b0;
            rd_address_out   <= 5'b0;
            csr_address_out  <= 12'b0;
            csr_write_out    <= 1'b0;
            mret_out         <= 1'b0;
            wfi_out          <= 1'b0;
        end else if (capture) begin
            pc_out           <= pc_in;
            next_pc_out      <= next_pc_in;
            alu_data_out     <= alu_data_in;
            csr_data_out     <= csr_data_in;
            write_select_out <= write_select_in;
            rd_address_out   <= rd_address_in;
            csr_address_out  <= csr_address_in;
            csr_write_out    <= csr_write_in;
            mret_out         <= mret_in;
            wfi_out          <= wfi_in;
        end
    end

    // Access FSM: this block owns the bus outputs, valid/exception and load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            killed        <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'b0;
            mem_wdata     <= 32'b0;
            mem_wstrb     <= 4'b0;
            valid_out     <= 1'b0;
            ecause_out    <= 4'b0;
            exception_out <= 1'b0;
            load_data_out <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    killed <= 1'b0;
                    if (start) begin
                        mem_req   <= 1'b1;
                        mem_we    <= store_in;
                        mem_addr  <= {alu_data_in[31:2], 2'b00};
                        mem_wdata <= wdata_rep;
                        mem_wstrb <= strobe;
                        valid_out <= 1'b0;
                        state     <= ACCESS;
                    end else if (!stall) begin
                        valid_out <= valid_in & ~invalidate;
                        if (mem_op & misaligned) begin
                            exception_out <= 1'b1;
                            ecause_out    <= load_in ? 4'd4 : 4'd6;
                        end else begin
                            exception_out <= exception_in;
                            ecause_out    <= ecause_in;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_req       <= 1'b0;
                        state         <= IDLE;
                        killed        <= 1'b0;
                        valid_out     <= ~killed & ~invalidate;
                        exception_out <= 1'b0;
                        ecause_out    <= ecause_in;
                        load_data_out <= load_fmt;
                    end else if (invalidate) begin
                        // The transfer cannot be aborted. Its result is
                        // dropped when it completes.
                        killed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access: reset, loads, stores, misalignment,
// stall/invalidate handling and bus handshake timing.
module tb_memory_access;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in, pc_out, next_pc_in, next_pc_out;
    logic [31:0] alu_data_in, alu_data_out, csr_data_in, csr_data_out;
    logic [31:0] rs2_data_in;
    logic        load_in, store_in, load_signed_in, bypass_memory_in;
    logic [1:0]  load_store_size_in, write_select_in, write_select_out;
    logic [4:0]  rd_address_in, rd_address_out;
    logic [11:0] csr_address_in, csr_address_out;
    logic        csr_write_in, csr_write_out, mret_in, mret_out, wfi_in, wfi_out;
    logic        valid_in, valid_out;
    logic [3:0]  ecause_in, ecause_out;
    logic        exception_in, exception_out;
    logic        stall, invalidate, mem_busy, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata, load_data_out;
    logic        debug_state;

    int total = 0;
    int bad   = 0;

    memory_access dut (
        .clk(clk), .reset(reset),
        .pc_in(pc_in), .pc_out(pc_out),
        .next_pc_in(next_pc_in), .next_pc_out(next_pc_out),
        .alu_data_in(alu_data_in), .alu_data_out(alu_data_out),
        .csr_data_in(csr_data_in), .csr_data_out(csr_data_out),
        .rs2_data_in(rs2_data_in),
        .load_in(load_in), .store_in(store_in),
        .load_store_size_in(load_store_size_in),
        .load_signed_in(load_signed_in),
        .bypass_memory_in(bypass_memory_in),
        .write_select_in(write_select_in), .write_select_out(write_select_out),
        .rd_address_in(rd_address_in), .rd_address_out(rd_address_out),
        .csr_address_in(csr_address_in), .csr_address_out(csr_address_out),
        .csr_write_in(csr_write_in), .csr_write_out(csr_write_out),
        .mret_in(mret_in), .mret_out(mret_out),
        .wfi_in(wfi_in), .wfi_out(wfi_out),
        .valid_in(valid_in), .valid_out(valid_out),
        .ecause_in(ecause_in), .ecause_out(ecause_out),
        .exception_in(exception_in), .exception_out(exception_out),
        .stall(stall), .invalidate(invalidate),
        .mem_busy(mem_busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .load_data_out(load_data_out),
        .debug_state(debug_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: return every input to an idle, non-memory value.
    task automatic clear_inputs();
        pc_in = 32'h0; next_pc_in = 32'h0; alu_data_in = 32'h0; csr_data_in = 32'h0;
        rs2_data_in = 32'h0; load_in = 1'b0; store_in = 1'b0;
        load_store_size_in = 2'b10; load_signed_in = 1'b0; bypass_memory_in = 1'b0;
        write_select_in = 2'b0; rd_address_in = 5'h0; csr_address_in = 12'h0;
        csr_write_in = 1'b0; mret_in = 1'b0; wfi_in = 1'b0; valid_in = 1'b0;
        ecause_in = 4'h0; exception_in = 1'b0; stall = 1'b0; invalidate = 1'b0;
        mem_ready = 1'b0; mem_rdata = 32'h0;
    endtask

    // Driver: advance one cycle, then settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: present a memory op.
    task automatic drive_mem(input logic ld, input logic st, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        valid_in = 1'b1; load_in = ld; store_in = st; load_store_size_in = size;
        load_signed_in = sgn; alu_data_in = addr; rs2_data_in = wd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick(); tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_out); end
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
        total++; if (debug_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", debug_state); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_word_load();
        int busy_cnt;
        int valid_cnt;
        busy_cnt = 0;
        valid_cnt = 0;
        drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        pc_in = 32'h40; rd_address_in = 5'd7;
        #1;
        busy_cnt += int'(mem_busy);
        tick();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL wl_req got=%b exp=1", mem_req); end
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL wl_addr got=%h exp=00000100", mem_addr); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wl_we got=%b exp=0", mem_we); end
        valid_cnt += int'(valid_out);
        for (int k = 0; k < 3; k++) begin
            busy_cnt += int'(mem_busy);
            tick();
            valid_cnt += int'(valid_out);
        end
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL wl_req_hold got=%b exp=1", mem_req); end
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        busy_cnt += int'(mem_busy);
        tick();
        valid_cnt += int'(valid_out);
        total++; if (load_data_out !== 32'hDEADBEEF) begin bad++; $display("FAIL wl_data got=%h exp=deadbeef", load_data_out); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL wl_req_drop got=%b exp=0", mem_req); end
        total++; if (pc_out !== 32'h40) begin bad++; $display("FAIL wl_pc got=%h exp=00000040", pc_out); end
        total++; if (rd_address_out !== 5'd7) begin bad++; $display("FAIL wl_rd got=%0d exp=7", rd_address_out); end
        clear_inputs();
        tick();
        valid_cnt += int'(valid_out);
        total++; if (busy_cnt != 4) begin bad++; $display("FAIL wl_busy_cycles got=%0d exp=4", busy_cnt); end
        total++; if (valid_cnt != 1) begin bad++; $display("FAIL wl_valid_pulses got=%0d exp=1", valid_cnt); end
    endtask

    task automatic test_byte_load(input logic sgn, input logic [31:0] exp_data);
        drive_mem(1'b1, 1'b0, 2'b00, sgn, 32'h103, 32'h0);
        tick();
        total++; if (mem_addr !== 32'h100) begin bad++; $display("FAIL bl_addr got=%h exp=00000100", mem_addr); end
        total++; if (mem_wstrb !== 4'b1000) begin bad++; $display("FAIL bl_strb got=%b exp=1000", mem_wstrb); end
        mem_ready = 1'b1; mem_rdata = 32'h80FFFFFF;
        tick();
        total++; if (load_data_out !== exp_data) begin bad++; $display("FAIL bl_data_s%0d got=%h exp=%h", sgn, load_data_out, exp_data); end
        clear_inputs();
        tick();
    endtask

    task automatic test_half_store();
        drive_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD);
        tick();
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL hs_we got=%b exp=1", mem_we); end
        total++; if (mem_addr !== 32'h200) begin bad++; $display("FAIL hs_addr got=%h exp=00000200", mem_addr); end
        total++; if (mem_wstrb !== 4'b1100) begin bad++; $display("FAIL hs_strb got=%b exp=1100", mem_wstrb); end
        total++; if (mem_wdata !== 32'hABCDABCD) begin bad++; $display("FAIL hs_wdata got=%h exp=abcdabcd", mem_wdata); end
        // Ready in the first cycle of the request: single-cycle access.
        mem_ready = 1'b1;
        #1;
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL hs_busy got=%b exp=0", mem_busy); end
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hs_req_drop got=%b exp=0", mem_req); end
        total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL hs_valid got=%b exp=1", valid_out); end
        total++; if (debug_state !== 1'b0) begin bad++; $display("FAIL hs_state got=%b exp=0", debug_state); end
        clear_inputs();
        tick();
    endtask

    task automatic test_misaligned();
        drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        #1;
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL ma_busy got=%b exp=0", mem_busy); end
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ma_req got=%b exp=0", mem_req); end
        total++; if (exception_out !== 1'b1) begin bad++; $display("FAIL ma_exc got=%b exp=1", exception_out); end
        total++; if (ecause_out !== 4'd4) begin bad++; $display("FAIL ma_cause_ld got=%0d exp=4", ecause_out); end
        drive_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h3, 32'h0);
        tick();
        total++; if (ecause_out !== 4'd6) begin bad++; $display("FAIL ma_cause_st got=%0d exp=6", ecause_out); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ma_req_st got=%b exp=0", mem_req); end
        clear_inputs();
        tick();
        total++; if (exception_out !== 1'b0) begin bad++; $display("FAIL ma_exc_clear got=%b exp=0", exception_out); end
    endtask

    task automatic test_stall();
        valid_in = 1'b1; pc_in = 32'h480; alu_data_in = 32'h1111;
        tick();
        total++; if (pc_out !== 32'h480) begin bad++; $display("FAIL st_pc_pre got=%h exp=00000480", pc_out); end
        pc_in = 32'h500; alu_data_in = 32'h1234; rd_address_in = 5'd5; stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (pc_out !== 32'h480) begin bad++; $display("FAIL st_pc_hold%0d got=%h exp=00000480", k, pc_out); end
            total++; if (alu_data_out !== 32'h1111) begin bad++; $display("FAIL st_alu_hold%0d got=%h exp=00001111", k, alu_data_out); end
        end
        stall = 1'b0;
        tick();
        total++; if (pc_out !== 32'h500) begin bad++; $display("FAIL st_pc_rel got=%h exp=00000500", pc_out); end
        total++; if (alu_data_out !== 32'h1234) begin bad++; $display("FAIL st_alu_rel got=%h exp=00001234", alu_data_out); end
        total++; if (rd_address_out !== 5'd5) begin bad++; $display("FAIL st_rd_rel got=%0d exp=5", rd_address_out); end
        invalidate = 1'b1;
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL st_inval_idle got=%b exp=0", valid_out); end
        clear_inputs();
        tick();
    endtask

    task automatic test_invalidate_access();
        drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ia_req_hold got=%b exp=1", mem_req); end
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ia_req_drop got=%b exp=0", mem_req); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL ia_valid got=%b exp=0", valid_out); end
        clear_inputs();
        tick();
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL ia_valid_after got=%b exp=0", valid_out); end
    endtask

    task automatic test_idle_ready();
        mem_ready = 1'b1;
        tick();
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ir_req got=%b exp=0", mem_req); end
        total++; if (debug_state !== 1'b0) begin bad++; $display("FAIL ir_state got=%b exp=0", debug_state); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_access();
        drive_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        tick();
        total++; if (debug_state !== 1'b1) begin bad++; $display("FAIL rm_state_acc got=%b exp=1", debug_state); end
        #2;
        reset = 1'b1;
        clear_inputs();
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b exp=0", mem_req); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", valid_out); end
        total++; if (mem_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", mem_busy); end
        tick();
        reset = 1'b0;
        tick();
        total++; if (debug_state !== 1'b0) begin bad++; $display("FAIL rm_state_idle got=%b exp=0", debug_state); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rm_req_after got=%b exp=0", mem_req); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_load(1'b1, 32'hFFFFFF80);
        test_byte_load(1'b0, 32'h00000080);
        test_half_store();
        test_misaligned();
        test_stall();
        test_invalidate_access();
        test_idle_ready();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
